genome_config_loader: RTL and testbench
=======================================

Name: genome_config_loader

Overview:
- Upstream configuration stage for the evolvable logic-element array.
- Accepts a byte stream carrying one chromosome (a per-element function select plus two input selects) over a valid/ready handshake and assembles it in a shadow register.
- Range-checks every gene and commits the complete chromosome atomically to the flat configuration bus that drives the logic elements.
- A malformed frame never disturbs the active configuration.

Parameters:
- N_ELEMS, 16, number of logic elements configured per frame (1..64).
- N_INPUTS, 27, size of each element's input pool; each 5-bit input select must be < N_INPUTS (max 32).
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte this cycle.
- conf_out  out  N_ELEMS*13  active configuration. Element k occupies [13k+12:13k]:
  - [13k+2:13k] = function select (3 bits).
  - [13k+7:13k+3] = input select A (5 bits).
  - [13k+12:13k+8] = input select B (5 bits).
- cfg_valid  out  1  high once any frame has committed since reset.
- load_done  out  1  one-cycle pulse on commit.
- load_err  out  1  one-cycle pulse on frame abort.
- busy  out  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- A transfer occurs on a rising clk edge with in_valid && in_ready. No other byte is consumed.
- Reset state:
  - conf_out = 0.
  - cfg_valid = 0, load_done = 0, load_err = 0, busy = 0.
  - FSM = IDLE, element counter = 0, shadow register = 0.
- Frame format: HEADER, then 2 bytes per element, element 0 first.
  - Byte L = {selA[4:0], func[2:0]}.
  - Byte H = {3'b000, selB[4:0]}.
- FSM states:
  - IDLE: in_ready = 1. A transferred byte equal to HEADER goes to LO with counter cleared. Any other byte is silently discarded.
  - LO: in_ready = 1. On transfer, store func and selA into the shadow slot for the current element; selA >= N_INPUTS goes to ABORT; otherwise go to HI.
  - HI: in_ready = 1. On transfer, byte[7:5] != 0 or selB >= N_INPUTS goes to ABORT. Otherwise store selB. If counter == N_ELEMS-1, go to COMMIT; else increment counter and go to LO.
  - COMMIT: in_ready = 0. conf_out <= shadow and cfg_valid <= 1 on this edge. load_done is high for exactly this cycle. Next state is IDLE.
  - ABORT: in_ready = 0. load_err is high for exactly this cycle. conf_out is unchanged and the shadow is not copied. Next state is IDLE.
- Latency: conf_out updates on the clock edge following the cycle in which the last H byte is transferred. Minimum frame length is 1 + 2*N_ELEMS transfers plus 1 COMMIT cycle.
- In LO/HI, a HEADER value is treated as ordinary data; there is no resynchronisation mid-frame.
- in_valid low in any state: hold state, shadow and counter unchanged. There is no timeout.
- Function select needs no range check; all 8 values are legal, including the single-input codes 2 and 7, whose selB is still checked and stored.
- Reset mid-frame returns to IDLE, discards the shadow, and clears conf_out to 0.
- Counter width is clog2(N_ELEMS), minimum 1 bit. The counter never wraps inside a frame.
- N_ELEMS = 1: HI goes directly to COMMIT after the first element.
- conf_out changes only in COMMIT and on reset. Between commits it is stable on every cycle.

Test Plan:
- Reset, then an idle stream -> conf_out = 0, cfg_valid = 0, busy = 0, in_ready = 1.
- Bytes 8'h11, 8'h22 then a valid frame (N_ELEMS = 16) with element k = {func = k%8, selA = k, selB = 26-k} -> leading garbage ignored; load_done pulses once, on the cycle after the 33rd transfer; element 3 slice = 13'b10111_00011_011; cfg_valid = 1.
- Valid frame with in_valid toggled randomly (about 50% duty) -> same conf_out as the uninterrupted frame; load_done pulses once.
- After a good commit, a frame whose element 5 selA = 27 -> load_err pulses in the cycle after that L byte; conf_out is identical to the previous commit; the next HEADER starts a fresh frame that commits.
- Frame with element 0 H byte = 8'h20 (reserved bit set) -> abort; load_err pulses once; load_done stays 0.
- Assert rst after element 8's H byte of a frame -> conf_out = 0, cfg_valid = 0, FSM = IDLE. A following complete frame commits correctly, with no stale shadow bits in elements 0-8.

Source files
------------

// File: rtl/genome_config_loader.sv
// genome_config_loader: byte-stream loader for the evolvable logic-element
// array configuration. Assembles one chromosome (func/selA/selB per element)
// in a shadow register, range-checks each gene, and commits the whole
// chromosome atomically to conf_out.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data/in_valid  stream byte and its valid
//   in_ready          loader accepts a byte this cycle
//   conf_out          active configuration, 13 bits per element
//                     {selB[4:0], selA[4:0], func[2:0]}
//   cfg_valid         a frame has committed since reset
//   load_done         one-cycle pulse on commit
//   load_err          one-cycle pulse on frame abort
//   busy              frame in progress (state != IDLE)
module genome_config_loader #(
  parameter int unsigned N_ELEMS  = 16,
  parameter int unsigned N_INPUTS = 27,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_ELEMS*13-1:0]  conf_out,
  output logic                   cfg_valid,
  output logic                   load_done,
  output logic                   load_err,
  output logic                   busy
);

  localparam int unsigned CW = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;

  typedef enum logic [2:0] {IDLE, LO, HI, COMMIT, ABORT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [12:0]     shadow [N_ELEMS];

  logic            xfer;
  logic            sel_a_bad;
  logic            hi_bad;
  logic            last_elem;

  // Gene checks on the byte currently offered
  always_comb begin
    xfer      = in_valid && in_ready;
    sel_a_bad = {1'b0, in_data[7:3]} >= 6'(N_INPUTS);
    hi_bad    = (in_data[7:5] != 3'b000) || ({1'b0, in_data[4:0]} >= 6'(N_INPUTS));
    last_elem = (cnt == CW'(N_ELEMS - 1));
  end

  // Frame FSM; all outputs are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      conf_out  <= '0;
      cfg_valid <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      for (int k = 0; k < N_ELEMS; k++) shadow[k] <= '0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer && in_data == HEADER) begin
            state <= LO;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        LO: begin
          if (xfer) begin
            shadow[cnt][7:0] <= in_data;
            if (sel_a_bad) begin
              state    <= ABORT;
              in_ready <= 1'b0;
              load_err <= 1'b1;
            end else begin
              state <= HI;
            end
          end
        end
        HI: begin
          if (xfer) begin
            if (hi_bad) begin
              state    <= ABORT;
              in_ready <= 1'b0;
              load_err <= 1'b1;
            end else begin
              shadow[cnt][12:8] <= in_data[4:0];
              if (last_elem) begin
                state     <= COMMIT;
                in_ready  <= 1'b0;
                load_done <= 1'b1;
              end else begin
                cnt   <= cnt + CW'(1);
                state <= LO;
              end
            end
          end
        end
        COMMIT: begin
          // Atomic copy of the fully assembled chromosome
          for (int k = 0; k < N_ELEMS; k++) conf_out[13*k +: 13] <= shadow[k];
          cfg_valid <= 1'b1;
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        ABORT: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_genome_config_loader.sv
// Directed bench for genome_config_loader (N_ELEMS=16, N_INPUTS=27).
module tb_genome_config_loader;

  localparam int unsigned NE = 16;
  localparam int unsigned CWID = NE * 13;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [CWID-1:0]  conf_out;
  logic             cfg_valid;
  logic             load_done;
  logic             load_err;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]      fl [NE];
  logic [7:0]      fh [NE];
  logic [CWID-1:0] exp_a;
  logic [CWID-1:0] exp_b;
  logic [12:0]     slice3;

  genome_config_loader #(.N_ELEMS(NE), .N_INPUTS(27), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .conf_out(conf_out), .cfg_valid(cfg_valid),
    .load_done(load_done), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CWID-1:0] obs, input logic [CWID-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Offer one byte; returns #1 after the edge that transferred it
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic gap(input bit en);
    if (en) repeat ($urandom_range(0, 1)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Header plus elements 0..n_el-1 from fl/fh
  task automatic send_frame(input int n_el, input bit gaps);
    send(8'hA5);
    for (int k = 0; k < n_el; k++) begin
      gap(gaps);
      send(fl[k]);
      gap(gaps);
      send(fh[k]);
    end
  endtask

  task automatic load_a();
    for (int k = 0; k < NE; k++) begin
      fl[k] = {5'(k), 3'(k % 8)};
      fh[k] = 8'(26 - k);
    end
  endtask

  task automatic load_b();
    for (int k = 0; k < NE; k++) begin
      fl[k] = {5'((k * 5 + 20) % 27), 3'(7 - (k % 8))};
      fh[k] = 8'((k * 3 + 1) % 27);
    end
    fl[0] = 8'hA5;  // header value used as data: func 5, selA 20
  endtask

  function automatic logic [CWID-1:0] pack();
    logic [CWID-1:0] v = '0;
    for (int k = 0; k < NE; k++) v[13*k +: 13] = {fh[k][4:0], fl[k]};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    chk("reset_conf", conf_out, '0);
    chk("reset_cfg_valid", CWID'(cfg_valid), CWID'(0));
    chk("reset_busy", CWID'(busy), CWID'(0));
    chk("reset_in_ready", CWID'(in_ready), CWID'(1));

    // Leading garbage then frame A
    load_a();
    exp_a = pack();
    send(8'h11);
    send(8'h22);
    chk("garbage_busy", CWID'(busy), CWID'(0));
    send_frame(NE, 1'b0);
    chk("a_done_pulse", CWID'(load_done), CWID'(1));
    chk("a_commit_ready", CWID'(in_ready), CWID'(0));
    tick();
    chk("a_done_once", CWID'(load_done), CWID'(0));
    tick();
    chk("a_conf", conf_out, exp_a);
    slice3 = conf_out[13*3 +: 13];
    chk("a_elem3", CWID'(slice3), CWID'(13'b10111_00011_011));
    chk("a_cfg_valid", CWID'(cfg_valid), CWID'(1));
    chk("a_idle_busy", CWID'(busy), CWID'(0));

    // Same frame with random idle gaps
    send_frame(NE, 1'b1);
    chk("gap_done_pulse", CWID'(load_done), CWID'(1));
    tick();
    chk("gap_done_once", CWID'(load_done), CWID'(0));
    tick();
    chk("gap_conf", conf_out, exp_a);

    // Element 5 selA = 27 aborts; conf unchanged
    send_frame(5, 1'b0);
    chk("mid_busy", CWID'(busy), CWID'(1));
    send({5'd27, 3'd1});
    chk("sela_err_pulse", CWID'(load_err), CWID'(1));
    chk("sela_no_done", CWID'(load_done), CWID'(0));
    tick();
    chk("sela_err_once", CWID'(load_err), CWID'(0));
    chk("sela_conf_kept", conf_out, exp_a);

    // Fresh frame B commits (contains header value as data)
    load_b();
    exp_b = pack();
    send_frame(NE, 1'b0);
    chk("b_done_pulse", CWID'(load_done), CWID'(1));
    repeat (2) tick();
    chk("b_conf", conf_out, exp_b);
    slice3 = conf_out[12:0];
    chk("b_elem0", CWID'(slice3), CWID'({5'd1, 8'hA5}));

    // Reserved bit in element 0 H byte
    send(8'hA5);
    send(fl[0]);
    send(8'h20);
    chk("rsv_err_pulse", CWID'(load_err), CWID'(1));
    chk("rsv_no_done", CWID'(load_done), CWID'(0));
    tick();
    chk("rsv_err_once", CWID'(load_err), CWID'(0));
    tick();
    chk("rsv_conf_kept", conf_out, exp_b);

    // Reset after element 8's H byte
    for (int k = 0; k < NE; k++) begin
      fl[k] = {5'd26, 3'd7};
      fh[k] = 8'd26;
    end
    send_frame(9, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_conf", conf_out, '0);
    chk("rst_cfg_valid", CWID'(cfg_valid), CWID'(0));
    chk("rst_busy", CWID'(busy), CWID'(0));
    chk("rst_ready", CWID'(in_ready), CWID'(1));

    // Frame A after reset: no stale bits from the aborted frame
    load_a();
    send_frame(NE, 1'b0);
    chk("post_rst_done", CWID'(load_done), CWID'(1));
    repeat (2) tick();
    chk("post_rst_conf", conf_out, exp_a);
    chk("post_rst_cfg_valid", CWID'(cfg_valid), CWID'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
